hazard_unit: RTL
================

// Module: hazard_unit
// PURPOSE
//  Pipeline control for the 5-stage MIPS core: drives stall/flush for the D->E register and forward selects.
//  Detects load-use, branch-compare and syscall hazards; tracks multi-cycle mult/div occupancy with a busy counter.
//  Sits beside the datapath, consuming stage fields (Rs/Rt/WriteReg, RegWrite/MemtoReg, mult/div/mf/sys).
// PARAMETERS
//  MUL_LAT  4   cycles mult occupies the HI/LO unit, counted from its E cycle (>=1)
//  DIV_LAT  32  cycles div occupies the HI/LO unit, counted from its E cycle (>=1)
// PORTS
//  clk                 in   1   clock, posedge
//  reset               in   1   synchronous, active-high
//  RsD, RtD            in   5   D-stage source registers
//  BranchD             in   1   D-stage branch compare in use
//  sysD                in   1   syscall in D (reads $v0=2, $a0=4)
//  multD, divD         in   1   mult/div in D
//  mfD                 in   2   mfhi/mflo in D (nonzero = active)
//  RsE, RtE            in   5   E-stage source registers
//  WriteRegE           in   5   E-stage destination
//  RegWriteE           in   1   E writes regfile
//  MemtoRegE           in   1   E is a load
//  multE, divE         in   1   mult/div in E
//  WriteRegM           in   5   M-stage destination
//  RegWriteM, MemtoRegM in  1   M writes regfile / M is a load
//  WriteRegW           in   5   W-stage destination
//  RegWriteW           in   1   W writes regfile
//  StallF, StallD      out  1   hold PC / hold F->D register
//  FlushE              out  1   clear D->E register (bubble)
//  ForwardAD, ForwardBD out 1   D compare operand from ALUOutM
//  ForwardAE, ForwardBE out 2   E operand: 00 regfile, 01 ResultW, 10 ALUOutM
//  StallCount, FlushCount out 32 perf counters (see CONFIGURATION)
// BEHAVIOUR
//  - Register $0 never forwarded or hazard-matched; all compares gated by src != 0.
//  - ForwardAE = 10 if RegWriteM && WriteRegM==RsE; else 01 if RegWriteW && WriteRegW==RsE; else 00. BE same w/ RtE. M wins.
//  - ForwardAD = RegWriteM && WriteRegM==RsD; BD same w/ RtD.
//  - lwstall = MemtoRegE && (RtE==RsD || RtE==RtD).
//  - brstall = BranchD && ((RegWriteE && WriteRegE in {RsD,RtD}) || (MemtoRegM && WriteRegM in {RsD,RtD})).
//  - sysstall = sysD && ((RegWriteE && WriteRegE in {2,4}) || (RegWriteM && WriteRegM in {2,4})).
//  - md_cnt (6b): load MUL_LAT-1 on multE, DIV_LAT-1 on divE; else decrement while !=0. busy = md_cnt!=0 || multE || divE.
//  - mdstall = busy && (mfD!=0 || multD || divD).
//  - stall = lwstall|brstall|sysstall|mdstall; StallF=StallD=FlushE=stall. All outputs combinational on inputs + md_cnt.
//  - Simultaneous hazards OR together; one bubble/cycle, no extra penalty.
//  - multE/divE while md_cnt!=0 impossible (mdstall); if forced, new load overwrites count.
//  - Reset (incl. mid-div): md_cnt<=0; while reset high FlushE=1, StallF=StallD=0, forwards 00.
// CONFIGURATION
//  HAZARD_PERF_EN defined: StallCount +1 each non-reset cycle StallD=1; FlushCount +1 each cycle FlushE=1 (excluding reset).
//   Both 32-bit, wrap FFFFFFFF->0, cleared by reset.
//  Undefined: no counter flops; StallCount/FlushCount tied to 0.
// TESTING
//  1 lw $8 in E (MemtoRegE=1,RtE=8), RsD=8 -> StallF=StallD=FlushE=1 one cycle; next cycle ForwardAE=01 for RsE=8.
//  2 RegWriteM=1,WriteRegM=5, RegWriteW=1,WriteRegW=5, RsE=5 -> ForwardAE=10; WriteRegM=0,RsE=0 -> 00.
//  3 divE pulse (DIV_LAT=32), mfD=01 held -> stall exactly 32 cycles starting divE cycle, released cycle 33.
//  4 multE then reset asserted 2 cycles later -> md_cnt=0 after reset; mfD=01 post-reset -> no stall.
//  5 BranchD, RsD=3, RegWriteE=1,WriteRegE=3 -> stall; next cycle RegWriteM=1,WriteRegM=3 -> ForwardAD=1, no stall.
//  6 HAZARD_PERF_EN: 5 lwstall cycles -> StallCount=5, FlushCount=5; preload FFFFFFFF +1 -> 0.

Source files
------------

// File: rtl/hazard_unit.sv
// Hazard detection and forwarding control for the 5-stage MIPS pipeline.
// Define HAZARD_PERF_EN to build the stall/flush performance counters.
module hazard_unit #(
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned DIV_LAT = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  RsD,
    input  logic [4:0]  RtD,
    input  logic        BranchD,
    input  logic        sysD,
    input  logic        multD,
    input  logic        divD,
    input  logic [1:0]  mfD,
    input  logic [4:0]  RsE,
    input  logic [4:0]  RtE,
    input  logic [4:0]  WriteRegE,
    input  logic        RegWriteE,
    input  logic        MemtoRegE,
    input  logic        multE,
    input  logic        divE,
    input  logic [4:0]  WriteRegM,
    input  logic        RegWriteM,
    input  logic        MemtoRegM,
    input  logic [4:0]  WriteRegW,
    input  logic        RegWriteW,
    output logic        StallF,
    output logic        StallD,
    output logic        FlushE,
    output logic        ForwardAD,
    output logic        ForwardBD,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic [31:0] StallCount,
    output logic [31:0] FlushCount
);

    logic [5:0] mdCntQ, mdCntD;
    logic       busy;
    logic       lwStall, brStall, sysStall, mdStall, stall;

    // $0 is hardwired, so a source of 0 never matches a producer.
    function automatic logic hit(input logic [4:0] src, input logic we, input logic [4:0] dst);
        return we && (src != 5'd0) && (src == dst);
    endfunction

    function automatic logic sysReg(input logic we, input logic [4:0] dst);
        return we && ((dst == 5'd2) || (dst == 5'd4));
    endfunction

    always_comb begin
        mdCntD = mdCntQ;
        if (divE) begin
            mdCntD = 6'(DIV_LAT - 1);
        end else if (multE) begin
            mdCntD = 6'(MUL_LAT - 1);
        end else if (mdCntQ != 6'd0) begin
            mdCntD = mdCntQ - 6'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mdCntQ <= 6'd0;
        end else begin
            mdCntQ <= mdCntD;
        end
    end

    always_comb begin
        busy     = (mdCntQ != 6'd0) || multE || divE;
        lwStall  = MemtoRegE && (hit(RsD, 1'b1, RtE) || hit(RtD, 1'b1, RtE));
        brStall  = BranchD &&
                   (hit(RsD, RegWriteE, WriteRegE) || hit(RtD, RegWriteE, WriteRegE) ||
                    hit(RsD, MemtoRegM, WriteRegM) || hit(RtD, MemtoRegM, WriteRegM));
        sysStall = sysD && (sysReg(RegWriteE, WriteRegE) || sysReg(RegWriteM, WriteRegM));
        mdStall  = busy && ((mfD != 2'b00) || multD || divD);
        stall    = lwStall || brStall || sysStall || mdStall;
    end

    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        FlushE    = 1'b1;
        ForwardAD = 1'b0;
        ForwardBD = 1'b0;
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (!reset) begin
            StallF    = stall;
            StallD    = stall;
            FlushE    = stall;
            ForwardAD = hit(RsD, RegWriteM, WriteRegM);
            ForwardBD = hit(RtD, RegWriteM, WriteRegM);
            // M stage holds the younger result, so it takes priority over W.
            if (hit(RsE, RegWriteM, WriteRegM)) begin
                ForwardAE = 2'b10;
            end else if (hit(RsE, RegWriteW, WriteRegW)) begin
                ForwardAE = 2'b01;
            end
            if (hit(RtE, RegWriteM, WriteRegM)) begin
                ForwardBE = 2'b10;
            end else if (hit(RtE, RegWriteW, WriteRegW)) begin
                ForwardBE = 2'b01;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stallCntQ, flushCntQ;

    always_ff @(posedge clk) begin
        if (reset) begin
            stallCntQ <= 32'd0;
            flushCntQ <= 32'd0;
        end else begin
            if (StallD) stallCntQ <= stallCntQ + 32'd1;
            if (FlushE) flushCntQ <= flushCntQ + 32'd1;
        end
    end

    assign StallCount = stallCntQ;
    assign FlushCount = flushCntQ;
`else
    assign StallCount = 32'd0;
    assign FlushCount = 32'd0;
`endif

endmodule
